// File: rtl/tb_arbiter_if.sv
// Buffer arbiter bus: scanout port A, terminal port B,
// clear control and the registered RAM side.
interface tb_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              clr_start;
  logic [DATA_W-1:0] clr_char;
  logic              clr_busy;
  logic              clr_done;

  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    output clr_start, clr_char,
    input  clr_busy, clr_done,
    input  m_wen, m_addr, m_wdata,
    output m_rdata
  );

  modport slave (
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    input  clr_start, clr_char,
    output clr_busy, clr_done,
    output m_wen, m_addr, m_wdata,
    input  m_rdata
  );
endinterface

// File: rtl/tb_arbiter.sv
// Text buffer arbiter: scanout (A) over terminal (B) with
// a starvation guard, plus a screen clear engine on the B slot.
module tb_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int CELLS      = 1000,
  parameter int MAX_STARVE = 8
) (
  input logic        clk,
  input logic        rst,
  tb_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  logic [DATA_W-1:0] clr_val, clr_val_nx;
  logic              done_nx;
  logic              b_pend, a_win, bc_win, clr_win, b_win;
  logic              clr_last;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [1:0]        own_v, own_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      clr_ptr       <= '0;
      clr_val       <= '0;
      bus.clr_done  <= 1'b0;
    end else begin
      state         <= state_nx;
      starve_cnt    <= starve_nx;
      clr_ptr       <= clr_ptr_nx;
      clr_val       <= clr_val_nx;
      bus.clr_done  <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    clr_val_nx = clr_val;
    done_nx    = 1'b0;
    starve_nx  = starve_cnt;
    b_pend     = 1'b0;
    a_win      = 1'b0;
    bc_win     = 1'b0;
    clr_last   = clr_ptr == ADDR_W'(CELLS - 1);

    // a clear starting this cycle outranks a terminal request
    unique case (state)
      IDLE:  b_pend = bus.b_req & ~bus.clr_start;
      CLEAR: b_pend = 1'b1;
    endcase

    if (!rst) begin
      a_win  = bus.a_req && (starve_cnt < SW'(MAX_STARVE));
      bc_win = !a_win && b_pend;
    end
    clr_win = bc_win && (state == CLEAR);
    b_win   = bc_win && (state == IDLE);

    if (bc_win || !b_pend)
      starve_nx = '0;
    else if (a_win && starve_cnt < SW'(MAX_STARVE))
      starve_nx = starve_cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
          clr_val_nx = bus.clr_char;
        end
      end
      CLEAR: begin
        if (clr_win) begin
          clr_ptr_nx = clr_ptr + 1'b1;
          if (clr_last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    addr_sel  = bus.b_addr;
    wdata_sel = bus.b_wdata;
    unique case (1'b1)
      a_win:   addr_sel = bus.a_addr;
      clr_win: begin
        addr_sel  = clr_ptr;
        wdata_sel = clr_val;
      end
      default: ;
    endcase
  end

  assign bus.a_gnt    = a_win;
  assign bus.b_gnt    = b_win;
  assign bus.clr_busy = state == CLEAR;

  // own_* tracks which port each in-flight read belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_wen    <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      own_v        <= '0;
      own_a        <= '0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      bus.m_wen <= clr_win | (b_win & bus.b_we);
      if (a_win || bc_win) begin
        bus.m_addr  <= addr_sel;
        bus.m_wdata <= wdata_sel;
      end
      own_v <= {own_v[0], a_win | (b_win & ~bus.b_we)};
      own_a <= {own_a[0], a_win};
      bus.a_rvalid <= own_v[1] & own_a[1];
      bus.b_rvalid <= own_v[1] & ~own_a[1];
      if (own_v[1] && own_a[1])
        bus.a_rdata <= bus.m_rdata;
      if (own_v[1] && !own_a[1])
        bus.b_rdata <= bus.m_rdata;
    end
  end
endmodule

// File: tb/tb_tb_arbiter.sv
// Bench for tb_arbiter: RAM model, reference memory and
// per-port read scoreboards with latency tags.
module tb_tb_arbiter;
  logic clk;
  logic rst;

  tb_arbiter_if #(.ADDR_W(10), .DATA_W(8)) ifc ();

  tb_arbiter #(
    .ADDR_W(10), .DATA_W(8), .CELLS(1000), .MAX_STARVE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int errors;
  int checks;
  int cyc;
  int wr_cnt;
  logic [9:0] wr_last;

  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] rd_q;
  bit         ram_ok;

  logic [7:0] aq[$];
  logic [7:0] bq[$];
  int         acq[$];
  int         bcq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
      ram_ok <= 1'b1;
    end else if (ifc.m_wen === 1'b1) begin
      ram[ifc.m_addr] <= ifc.m_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_last <= ifc.m_addr;
    end
    rd_q <= ram[ifc.m_addr];
  end
  assign ifc.m_rdata = rd_q;

  always @(negedge clk) begin
    if (ifc.a_gnt && ifc.b_gnt)
      check("one_gnt", {31'd0, ifc.b_gnt}, 32'd0);
    if (ifc.a_rvalid === 1'b1) begin
      if (aq.size() == 0) check("a_rv_unexp", 32'(aq.size()), 32'd1);
      else begin
        check("a_rdata", 32'(ifc.a_rdata), 32'(aq.pop_front()));
        check("a_lat", 32'(cyc - acq.pop_front()), 32'd3);
      end
    end
    if (ifc.b_rvalid === 1'b1) begin
      if (bq.size() == 0) check("b_rv_unexp", 32'(bq.size()), 32'd1);
      else begin
        check("b_rdata", 32'(ifc.b_rdata), 32'(bq.pop_front()));
        check("b_lat", 32'(cyc - bcq.pop_front()), 32'd3);
      end
    end
  end

  task automatic push_a(input int addr);
    aq.push_back(ref_mem[addr]);
    acq.push_back(cyc);
  endtask

  task automatic push_b(input int addr);
    bq.push_back(ref_mem[addr]);
    bcq.push_back(cyc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic b_op(input bit we, input int addr, input logic [7:0] d);
    int n = 0;
    ifc.b_req   = 1'b1;
    ifc.b_we    = we;
    ifc.b_addr  = 10'(addr);
    ifc.b_wdata = d;
    @(negedge clk);
    while (!ifc.b_gnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("b_gnt_wait", {31'd0, ifc.b_gnt}, 32'd1);
    if (ifc.b_gnt) begin
      if (we) ref_mem[addr] = d;
      else push_b(addr);
    end
    step();
    ifc.b_req = 1'b0;
  endtask

  task automatic a_reads(input int base, input int n, output int t);
    int i = 0;
    t = 0;
    ifc.a_req  = 1'b1;
    ifc.a_addr = 10'(base);
    while (i < n && t < 20000) begin
      @(negedge clk);
      if (ifc.a_gnt) begin
        push_a(base + i);
        i++;
      end
      step();
      t++;
      ifc.a_addr = 10'(base + i);
    end
    ifc.a_req = 1'b0;
    check("a_reads_n", 32'(i), 32'(n));
  endtask

  task automatic drain;
    int t = 0;
    while ((aq.size() + bq.size()) != 0 && t < 200) begin
      step();
      t++;
    end
    check("drain", 32'(aq.size() + bq.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dc, bg, viol, t, w0, cnt;
    bit exp_b;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    rst = 1'b1;
    ifc.a_req = 1'b1;  ifc.a_addr = '0;
    ifc.b_req = 1'b1;  ifc.b_we = 1'b0;
    ifc.b_addr = '0;   ifc.b_wdata = '0;
    ifc.clr_start = 1'b0;
    ifc.clr_char  = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_gnt", {30'd0, ifc.a_gnt, ifc.b_gnt}, 32'd0);
    check("rst_ctl", {27'd0, ifc.clr_busy, ifc.clr_done,
          ifc.a_rvalid, ifc.b_rvalid, ifc.m_wen}, 32'd0);
    check("rst_data", {8'd0, ifc.a_rdata, ifc.b_rdata, ifc.m_wdata},
          32'd0);
    check("rst_addr", 32'(ifc.m_addr), 32'd0);
    step();
    ifc.a_req = 1'b0;
    ifc.b_req = 1'b0;
    rst = 1'b0;
    step();

    // write then read through B
    b_op(1'b1, 288, 8'h41);
    b_op(1'b0, 288, 8'h00);
    drain();

    // A and B contending: 8 A, 1 B, 8 A, 1 B
    ifc.a_req = 1'b1;  ifc.a_addr = 10'd7;
    ifc.b_req = 1'b1;  ifc.b_we = 1'b0;  ifc.b_addr = 10'd5;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      exp_b = (k == 8) || (k == 17);
      check("pri_a", {31'd0, ifc.a_gnt}, {31'd0, !exp_b});
      check("pri_b", {31'd0, ifc.b_gnt}, {31'd0, exp_b});
      if (ifc.a_gnt) push_a(7);
      if (ifc.b_gnt) push_b(int'(ifc.b_addr));
      step();
      if (k == 8) ifc.b_addr = 10'd6;
    end
    ifc.a_req = 1'b0;
    ifc.b_req = 1'b0;
    drain();

    // back-to-back A burst
    a_reads(0, 40, t);
    check("a_b2b", 32'(t), 32'd40);
    drain();

    // clear with no A traffic
    w0 = wr_cnt;
    s = -1;  dc = -1;
    ifc.clr_char  = 8'h20;
    ifc.clr_start = 1'b1;
    for (int k = 0; k < 2000 && dc < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s = cyc;
        check("clr_busy0", {31'd0, ifc.clr_busy}, 32'd0);
      end
      if (k == 1) check("clr_busy1", {31'd0, ifc.clr_busy}, 32'd1);
      if (ifc.clr_done) begin
        dc = cyc;
        for (int i = 0; i < 1000; i++) ref_mem[i] = 8'h20;
      end
      step();
      ifc.clr_start = 1'b0;
    end
    check("clr_len", 32'(dc - s), 32'd1001);
    check("clr_writes", 32'(wr_cnt - w0), 32'd1000);
    check("clr_last", 32'(wr_last), 32'd999);
    check("clr_idle", {31'd0, ifc.clr_busy}, 32'd0);
    a_reads(0, 1, t);
    a_reads(500, 1, t);
    a_reads(999, 1, t);
    a_reads(1000, 1, t);
    drain();

    // clear under continuous A; B write must wait for done
    s = -1;  dc = -1;  bg = -1;  viol = 0;
    ifc.a_req = 1'b1;  ifc.a_addr = 10'd1010;
    ifc.clr_char  = 8'h2E;
    ifc.clr_start = 1'b1;
    for (int k = 0; k < 12000 && bg < 0; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      if (ifc.a_gnt) push_a(1010);
      if (ifc.b_gnt && dc < 0) viol++;
      if (ifc.b_gnt) begin
        bg = cyc;
        ref_mem[1005] = 8'h77;
      end
      if (ifc.clr_done && dc < 0) begin
        dc = cyc;
        for (int i = 0; i < 1000; i++) ref_mem[i] = 8'h2E;
      end
      step();
      ifc.clr_start = 1'b0;
      if (k == 100) begin
        ifc.b_req = 1'b1;  ifc.b_we = 1'b1;
        ifc.b_addr = 10'd1005;  ifc.b_wdata = 8'h77;
      end
      if (bg >= 0) ifc.b_req = 1'b0;
    end
    ifc.a_req = 1'b0;
    check("clrA_len", 32'(dc - s), 32'd9001);
    check("clrA_bwait", 32'(bg - dc), 32'd8);
    check("clrA_block", 32'(viol), 32'd0);
    drain();
    b_op(1'b0, 1005, 8'h00);
    a_reads(3, 1, t);
    drain();

    // reset while the clear sits at cell 300
    w0 = wr_cnt;
    ifc.clr_char  = 8'h11;
    ifc.clr_start = 1'b1;
    step();
    ifc.clr_start = 1'b0;
    repeat (300) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("abort_addr", 32'(ifc.m_addr), 32'd0);
    check("abort_wdata", 32'(ifc.m_wdata), 32'd0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.m_wen || ifc.clr_busy || ifc.clr_done) cnt++;
      step();
    end
    check("abort_quiet", 32'(cnt), 32'd0);
    check("abort_writes", 32'(wr_cnt - w0), 32'd300);
    for (int i = 0; i < 300; i++) ref_mem[i] = 8'h11;
    b_op(1'b0, 299, 8'h00);
    b_op(1'b0, 300, 8'h00);
    drain();

    // read in flight when reset hits must never return
    ifc.a_req = 1'b1;  ifc.a_addr = 10'd3;
    @(negedge clk);
    check("flight_gnt", {31'd0, ifc.a_gnt}, 32'd1);
    step();
    ifc.a_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifc.a_rvalid || ifc.b_rvalid) cnt++;
      step();
    end
    check("flight_rv", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tb_arbiter.md
# tb_arbiter

Shares the single-port 1024x8 text buffer between two requesters: the video scanout (read-only, port A) and the terminal command engine (read/write, port B). Also contains a clear engine that fills the visible 40x25 screen with a fill character. Fixed priority goes to A, with a starvation guard for B. Sits between `termbuffer`-style command logic, the display refresh logic and the `buffer` RAM instance.

## Interface
Parameters:
- `ADDR_W`, 10: buffer address width.
- `DATA_W`, 8: character width.
- `CELLS`, 1000: visible cells (40x25) swept by the clear engine.
- `MAX_STARVE`, 8: consecutive A grants allowed while B-class is pending.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `a_req`  in  1: scanout read request; held until granted.
- `a_addr`  in  ADDR_W: scanout address.
- `a_gnt`  out  1: combinational grant for A this cycle.
- `a_rvalid`  out  1: A read data valid.
- `a_rdata`  out  DATA_W: A read data.
- `b_req`  in  1: terminal request; held until granted.
- `b_we`  in  1: 1 = write, 0 = read.
- `b_addr`  in  ADDR_W: terminal address.
- `b_wdata`  in  DATA_W: terminal write data.
- `b_gnt`  out  1: combinational grant for B this cycle.
- `b_rvalid`  out  1: B read data valid. Never pulses for writes.
- `b_rdata`  out  DATA_W: B read data.
- `clr_start`  in  1: one-cycle pulse that starts a clear.
- `clr_char`  in  DATA_W: fill value, sampled at `clr_start`.
- `clr_busy`  out  1: clear in progress.
- `clr_done`  out  1: one-cycle pulse after the last clear write.
- `m_wen`  out  1: RAM write enable (registered).
- `m_addr`  out  ADDR_W: RAM address (registered).
- `m_wdata`  out  DATA_W: RAM write data (registered).
- `m_rdata`  in  DATA_W: RAM read data, valid one cycle after `m_addr` is presented.

## Operation
- **B-class requester.** This is `b_req` when state is IDLE, or the clear engine when state is CLEAR. While CLEAR, `b_gnt` = 0 and B waits.
- **Grant rule, per cycle:**
  - If `a_req` is high and `starve_cnt` < MAX_STARVE, A is granted.
  - Else if B-class is pending, B-class is granted.
  - Else there is no grant, and `m_wen` is registered to 0.
- **One grant per cycle.** `a_gnt` and `b_gnt` are never both 1.
- **`starve_cnt`.**
  - Increments when A is granted while B-class is pending.
  - Clears when B-class is granted, or when B-class is not pending.
  - Saturates at MAX_STARVE.
- **Clear engine states.**
  - IDLE -> CLEAR on `clr_start`. This latches `clr_char` and sets `clr_ptr` = 0.
  - In CLEAR, each B-class grant writes `clr_char` to `clr_ptr`, then `clr_ptr` increments.
  - After the grant at `clr_ptr` = CELLS-1, the state returns to IDLE and `clr_done` pulses the next cycle.
- **Clear boundary conditions.**
  - `clr_start` while CLEAR is ignored.
  - `clr_start` in the same cycle as `b_req`: the clear wins and B waits.
- **Read tracking.** A 2-deep owner pipe tags each granted read as A or B. Data returns to the tagged port only.
- **Addresses.** Passed through unmodified. Addresses >= CELLS are legal for A and B, and `ADDR_W` wraps naturally.
- **Reset.** Aborts any clear immediately, with no further writes. Reset values:
  - `starve_cnt` = 0, `clr_ptr` = 0, state IDLE.
  - `clr_busy` = 0, `clr_done` = 0.
  - `a_rvalid` = 0, `b_rvalid` = 0.
  - `a_rdata` = 0, `b_rdata` = 0.
  - `m_wen` = 0, `m_addr` = 0, `m_wdata` = 0.
  - Grants are forced to 0 while `rst` is high.

## Timing
- **Cycle N (grant).** A grant in cycle N registers `m_addr`, `m_wen` and `m_wdata` at the end of N. The RAM samples them at the end of N+1.
- **Cycle N+2 (read return).** For a read granted in N, `m_rdata` is valid in N+2. `*_rdata` is registered with `*_rvalid` = 1 in N+3. Read latency is therefore 3 cycles from grant.
- **Write completion.** A write granted in N is in RAM after the N+1 edge. A read of the same address granted in N+1 returns the new value.
- **Throughput.** One access per cycle. Back-to-back grants to the same port are allowed.
- **Clear duration.** With no A traffic, a clear takes exactly CELLS cycles of writes.
  - `clr_busy` is 1 from the cycle after `clr_start` through the cycle of the last grant.
  - `clr_done` = 1 the cycle after the last grant.
- **Worst-case B wait under continuous `a_req`.** MAX_STARVE cycles of A, then 1 B-class slot, repeating.
- **Reset during reads.** Reads in flight when `rst` asserts never produce `rvalid`.

## Test plan
- Reset then idle: all outputs 0; B writes 0x41 to 288, then B reads 288 -> `b_rvalid` pulses 3 cycles after `b_gnt` with `b_rdata` = 0x41.
- `a_req` and `b_req` held high together (B read of 5) -> `a_gnt` for 8 cycles, then `b_gnt` for 1 cycle, then `a_gnt` resumes; `starve_cnt` clears after the B grant.
- A reads 0..39 back-to-back with no B -> 40 consecutive `a_rvalid` pulses, in address order, with matching data.
- `clr_start` with `clr_char` = 0x20 and no A traffic -> writes to addresses 0..999; `clr_done` pulses 1000 cycles after the first grant; reads of 0, 500, 999 return 0x20 and a read of 1000 keeps its prior value.
- Clear with `a_req` held high -> clear advances one cell every 9 cycles and still completes; `b_req` issued mid-clear gets `b_gnt` only after `clr_done`.
- `rst` asserted at `clr_ptr` = 300 -> no further `m_wen`, `clr_busy` = 0, no `clr_done`; cell 300 keeps its pre-clear value.
